tft_spi_rx: RTL
===============

Name: tft_spi_rx

Overview:
SPI slave receiver: the far end of the TFT SPI transmit link. It oversamples the serial lines (SCLK, MOSI, CS_n, DC) in the system clock domain, deserialises MSB-first words and queues them in a small FIFO with a valid/ready output.
It serves as the display-side decoder for loopback and self-check of the TFT SPI master, and as the front end of a future on-chip display model.

Parameters:
WORD_W, 16, bits per SPI word (8 or 16 supported)
FIFO_DEPTH, 4, received-word FIFO entries (power of two, >=2)
SYNC_STAGES, 2, synchroniser flops on each serial input (>=2)

Ports:
sys_clk_i  in  1  system clock; must run at >=4x SCLK frequency
sys_rst_i  in  1  synchronous active-high reset
spi_clk_i  in  1  SPI clock from master, idle low (mode 0)
spi_mosi_i  in  1  serial data, MSB first
spi_cs_n_i  in  1  chip select, active low, frames words
spi_dc_i  in  1  TFT data/command flag, sampled with the last bit of each word
data_o  out  WORD_W  head-of-FIFO word
dc_o  out  1  DC flag of the head word
valid_o  out  1  FIFO non-empty
ready_i  in  1  consumer accepts head word when valid_o & ready_i
level_o  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
overflow_o  out  1  one-cycle pulse: completed word dropped because FIFO full
frame_err_o  out  1  one-cycle pulse: CS_n deasserted with partial word

Behaviour:
- Reset (sync, active-high): FIFO empty; valid_o=0, level_o=0, data_o=0, dc_o=0, overflow_o=0, frame_err_o=0; bit counter=0; FSM=IDLE; synchroniser and edge-history flops load 0 for SCLK and 1 for CS_n. Reset mid-word discards the partial word.
- Input sync: each serial input passes SYNC_STAGES flops, followed by one history flop. sclk_rise = sync & ~hist. cs_rise/cs_fall are derived the same way.
- FSM:
  - IDLE: wait for synced CS_n low, go to SHIFT with bit counter=0. SCLK edges in IDLE are ignored.
  - SHIFT: on each sclk_rise, shreg <= {shreg[WORD_W-2:0], mosi_sync} and cnt++. When cnt reaches WORD_W-1 on a rise, the word is complete: latch {dc_sync, new shreg} into the write port, set cnt=0 and stay in SHIFT, so back-to-back words need no CS toggle. On synced CS_n high: go to IDLE. If cnt!=0, pulse frame_err_o and discard the partial word.
  - Word completion and CS rise in the same cycle: the word is complete and pushed, with no frame_err.
- Latency: SCLK rising edge first captured at sys_clk edge N gives shreg updated at edge N+SYNC_STAGES. For the last bit, the FIFO write and valid_o=1 occur at edge N+SYNC_STAGES+1 (N+3 at defaults).
- FIFO: synchronous, first-word-fall-through. data_o/dc_o show the head whenever valid_o=1 and hold stable until popped.
  - Pop on valid_o & ready_i.
  - Push and pop in the same cycle with FIFO full: both happen and level is unchanged. With FIFO empty, push only, since a pop needs valid_o.
  - Push when full without a simultaneous pop: word dropped, overflow_o pulses, FIFO contents untouched.
  - Pointers wrap modulo FIFO_DEPTH. level_o ranges 0..FIFO_DEPTH.
- data_o is don't-care when valid_o=0, but must not change on a cycle with no push or pop.
- SCLK faster than sys_clk/4 is unsupported. No error detection is required for it.

Decomposition:
- Shared package tft_spi_pkg: WORD_W default, SPI mode constant (mode 0), FSM state enum {IDLE, SHIFT}, and the FIFO entry typedef {dc, data[WORD_W-1:0]}. The TFT SPI master reuses the same package.
- One natural sub-module: tft_spi_fifo, a generic sync FWFT FIFO (width WORD_W+1, depth FIFO_DEPTH, push/pop/full/empty/level).
- Synchroniser, edge detect, FSM and shifter stay in tft_spi_rx.

Test Plan:
- Single word: CS_n low, send 16'hA55A with DC=1 at SCLK = sys_clk/8, ready_i=1 -> valid_o pulses 1 cycle, data_o=16'hA55A, dc_o=1, level_o returns to 0, no error pulses.
- Back-to-back: one CS frame carrying 16'h0001, 16'hFFFF, 16'h8000 (DC=0), ready_i=0 -> level_o=3, then pops in order 0001, FFFF, 8000.
- Overflow: ready_i=0, send 5 words 16'h0010..16'h0014 -> level_o=4, overflow_o pulses once on the 5th word, FIFO holds 0010..0013.
- Abort: CS_n rises after 9 bits of 16'hFFFF -> frame_err_o pulses once, level_o unchanged. The next full word 16'h1234 is received correctly.
- Full+simultaneous: FIFO full, ready_i=1 in the cycle a new word completes -> no overflow, level_o stays 4, head advances.
- Reset mid-word: assert sys_rst_i for 1 cycle after 7 bits -> all outputs 0 next cycle. The following 16'hBEEF frame is received intact.

Source files
------------

// File: rtl/tft_spi_pkg.sv
// rtl/tft_spi_pkg.sv - shared TFT SPI constants, FSM states and FIFO entry type
package tft_spi_pkg;

   localparam int WORD_W_DEF = 16;

   // Mode 0: SCLK idles low, data sampled on the rising edge
   localparam int SPI_MODE = 0;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_state_e;

   // Plain vector encodings of the same states for legacy-style FSM registers
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   typedef struct packed {
      logic                  dc;
      logic [WORD_W_DEF-1:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/tft_spi_rx_if.sv
// rtl/tft_spi_rx_if.sv - serial inputs and received-word stream of the SPI receiver
interface tft_spi_rx_if #(
   parameter int WORD_W = 16,
   parameter int LVL_W  = 3
);
   logic              spi_clk_i;
   logic              spi_mosi_i;
   logic              spi_cs_n_i;
   logic              spi_dc_i;
   logic [WORD_W-1:0] data_o;
   logic              dc_o;
   logic              valid_o;
   logic              ready_i;
   logic [LVL_W-1:0]  level_o;
   logic              overflow_o;
   logic              frame_err_o;

   modport slave (
      input  spi_clk_i, spi_mosi_i, spi_cs_n_i, spi_dc_i, ready_i,
      output data_o, dc_o, valid_o, level_o, overflow_o, frame_err_o
   );

   modport master (
      output spi_clk_i, spi_mosi_i, spi_cs_n_i, spi_dc_i, ready_i,
      input  data_o, dc_o, valid_o, level_o, overflow_o, frame_err_o
   );
endinterface

// File: rtl/tft_spi_fifo.sv
// rtl/tft_spi_fifo.sv - synchronous first-word-fall-through FIFO with drop-on-full
module tft_spi_fifo #(
   parameter int W     = 17,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop & ~empty;
   // A full FIFO still accepts a word when the head leaves in the same cycle
   assign do_push = push & (~full | do_pop);
   // Head is forced to zero while empty so the output is clean after reset
   assign pop_data = empty ? '0 : mem[rd_ptr];

   // Storage write; slot contents need no reset since empty masks them
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer, occupancy and overflow-pulse bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= push & full & ~do_pop;
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end
endmodule

// File: rtl/tft_spi_rx.sv
// rtl/tft_spi_rx.sv - oversampling SPI mode-0 slave receiver with word FIFO
module tft_spi_rx
   import tft_spi_pkg::*;
#(
   parameter int WORD_W      = WORD_W_DEF,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic         sys_clk_i,
   input  logic         sys_rst_i,
   tft_spi_rx_if.slave  bus
);
   localparam int CNT_W = $clog2(WORD_W);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

   logic [SYNC_STAGES-1:0] sclk_s;
   logic [SYNC_STAGES-1:0] mosi_s;
   logic [SYNC_STAGES-1:0] cs_s;
   logic [SYNC_STAGES-1:0] dc_s;
   logic                   sclk_h;

   logic sclk_sync;
   logic mosi_sync;
   logic cs_sync;
   logic dc_sync;
   logic sclk_rise;

   logic [0:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [WORD_W-1:0] shreg;
   logic [WORD_W-1:0] shreg_nxt;
   logic              word_done;
   logic              wr_en;
   logic [WORD_W:0]   wr_entry;
   logic              frame_err;

   logic [WORD_W:0]   head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [LVL_W-1:0]  fifo_level;
   logic              fifo_ovf;

   assign sclk_sync = sclk_s[SYNC_STAGES-1];
   assign mosi_sync = mosi_s[SYNC_STAGES-1];
   assign cs_sync   = cs_s[SYNC_STAGES-1];
   assign dc_sync   = dc_s[SYNC_STAGES-1];
   assign sclk_rise = sclk_sync & ~sclk_h;

   assign shreg_nxt = {shreg[WORD_W-2:0], mosi_sync};
   assign word_done = sclk_rise && (cnt == CNT_LAST);

   // Bring the serial lines into sys_clk; SCLK/CS_n reset to their idle levels
   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         sclk_s <= '0;
         mosi_s <= '0;
         cs_s   <= '1;
         dc_s   <= '0;
         sclk_h <= 1'b0;
      end else begin
         sclk_s <= {sclk_s[SYNC_STAGES-2:0], bus.spi_clk_i};
         mosi_s <= {mosi_s[SYNC_STAGES-2:0], bus.spi_mosi_i};
         cs_s   <= {cs_s[SYNC_STAGES-2:0],   bus.spi_cs_n_i};
         dc_s   <= {dc_s[SYNC_STAGES-2:0],   bus.spi_dc_i};
         sclk_h <= sclk_sync;
      end
   end

   // Framing FSM and shifter; a finished word takes priority over a CS abort
   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         shreg     <= '0;
         wr_en     <= 1'b0;
         wr_entry  <= '0;
         frame_err <= 1'b0;
      end else begin
         wr_en     <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (!cs_sync) begin
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (sclk_rise) begin
                  shreg <= shreg_nxt;
                  if (word_done) begin
                     wr_en    <= 1'b1;
                     wr_entry <= {dc_sync, shreg_nxt};
                     cnt      <= '0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               if (cs_sync) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
                  if ((cnt != '0) && !word_done) begin
                     frame_err <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   tft_spi_fifo #(
      .W     (WORD_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (sys_clk_i),
      .rst       (sys_rst_i),
      .push      (wr_en),
      .push_data (wr_entry),
      .pop       (bus.ready_i),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level),
      .overflow  (fifo_ovf)
   );

   assign bus.data_o      = head[WORD_W-1:0];
   assign bus.dc_o        = head[WORD_W];
   assign bus.valid_o     = ~fifo_empty;
   assign bus.level_o     = fifo_level;
   assign bus.overflow_o  = fifo_ovf;
   assign bus.frame_err_o = frame_err;

   logic unused_full;
   assign unused_full = fifo_full;
endmodule
